// File: rtl/axis_frame_packer.sv
// Frames an arbitrary-length host character stream into fixed N-character
// AXI-Stream frames: short messages are padded, long ones truncated.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_FILL    | passing host characters into the current frame
// ST_PAD     | host message ended early; emitting PAD_CHAR up to beat N-1
// ST_DISCARD | frame full; draining and dropping host beats until TLAST
module axis_frame_packer #(
   parameter int                  CHAR_LEN = 8,
   parameter int                  N        = 16,
   parameter logic [CHAR_LEN-1:0] PAD_CHAR = 8'hff
) (
   input  logic                ACLK,
   input  logic                ARESET,
   input  logic [CHAR_LEN-1:0] S_AXIS_TDATA,
   input  logic                S_AXIS_TVALID,
   input  logic                S_AXIS_TLAST,
   output logic                S_AXIS_TREADY,
   output logic [CHAR_LEN-1:0] M_AXIS_TDATA,
   output logic                M_AXIS_TVALID,
   output logic                M_AXIS_TLAST,
   input  logic                M_AXIS_TREADY,
   output logic                frame_done,
   output logic                truncated,
   output logic                padded
);

   localparam int             CW       = $clog2(N);
   localparam logic [CW-1:0]  CNT_LAST = CW'(N - 1);

   typedef enum logic [1:0] {
      ST_FILL    = 2'd0,
      ST_PAD     = 2'd1,
      ST_DISCARD = 2'd2
   } state_t;

   state_t              state;
   state_t              state_nxt;
   logic [CW-1:0]       cnt;
   logic [CW-1:0]       cnt_nxt;
   logic                pad_first;
   logic                pad_first_nxt;

   logic                out_valid;
   logic [CHAR_LEN-1:0] out_data;
   logic                out_last;

   logic                load_ok;
   logic                at_last;
   logic                load;
   logic [CHAR_LEN-1:0] load_data;
   logic                load_last;
   logic                s_ready;
   logic                padded_c;
   logic                truncated_c;

   // Next-state, load decision and handshake/pulse outputs.
   always_comb begin
      state_nxt     = state;
      cnt_nxt       = cnt;
      pad_first_nxt = pad_first;
      load          = 1'b0;
      load_data     = out_data;
      load_last     = 1'b0;
      s_ready       = 1'b0;
      padded_c      = 1'b0;
      truncated_c   = 1'b0;
      load_ok       = !out_valid || M_AXIS_TREADY;
      at_last       = (cnt == CNT_LAST);

      case (state)
         ST_FILL: begin
            s_ready = load_ok;
            if (S_AXIS_TVALID && load_ok) begin
               load      = 1'b1;
               load_data = S_AXIS_TDATA;
               load_last = at_last;
               cnt_nxt   = at_last ? '0 : cnt + CW'(1);
               if (S_AXIS_TLAST && !at_last) begin
                  state_nxt     = ST_PAD;
                  pad_first_nxt = 1'b1;
               end else if (!S_AXIS_TLAST && at_last) begin
                  state_nxt = ST_DISCARD;
               end
            end
         end
         ST_PAD: begin
            if (load_ok) begin
               load          = 1'b1;
               load_data     = PAD_CHAR;
               load_last     = at_last;
               cnt_nxt       = at_last ? '0 : cnt + CW'(1);
               padded_c      = pad_first;
               pad_first_nxt = 1'b0;
               if (at_last) begin
                  state_nxt = ST_FILL;
               end
            end
         end
         ST_DISCARD: begin
            // Host draining is decoupled from the output register so a
            // stalled final beat never blocks the excess characters.
            s_ready = 1'b1;
            if (S_AXIS_TVALID && S_AXIS_TLAST) begin
               truncated_c = 1'b1;
               state_nxt   = ST_FILL;
            end
         end
         default: begin
            state_nxt = ST_FILL;
         end
      endcase

      S_AXIS_TREADY = s_ready && !ARESET;
      padded        = padded_c && !ARESET;
      truncated     = truncated_c && !ARESET;
      frame_done    = out_valid && M_AXIS_TREADY && out_last && !ARESET;
   end

   // FSM state, beat counter and first-pad flag.
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         state     <= ST_FILL;
         cnt       <= '0;
         pad_first <= 1'b0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         pad_first <= pad_first_nxt;
      end
   end

   // Single-entry output register; data/last only change on a load.
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_last  <= 1'b0;
      end else if (load) begin
         out_valid <= 1'b1;
         out_data  <= load_data;
         out_last  <= load_last;
      end else if (M_AXIS_TREADY) begin
         out_valid <= 1'b0;
      end
   end

   assign M_AXIS_TVALID = out_valid;
   assign M_AXIS_TDATA  = out_data;
   assign M_AXIS_TLAST  = out_last;

endmodule

// File: tb/tb_axis_frame_packer.sv
// Scoreboard bench for axis_frame_packer: expected frame beats are queued as
// host characters are driven and popped as downstream handshakes occur.
module tb_axis_frame_packer;

   localparam int         CHAR_LEN = 8;
   localparam int         N        = 16;
   localparam logic [7:0] PADC     = 8'hff;

   logic                ACLK;
   logic                ARESET;
   logic [CHAR_LEN-1:0] S_AXIS_TDATA;
   logic                S_AXIS_TVALID;
   logic                S_AXIS_TLAST;
   logic                S_AXIS_TREADY;
   logic [CHAR_LEN-1:0] M_AXIS_TDATA;
   logic                M_AXIS_TVALID;
   logic                M_AXIS_TLAST;
   logic                M_AXIS_TREADY;
   logic                frame_done;
   logic                truncated;
   logic                padded;

   int checks   = 0;
   int failures = 0;

   logic [CHAR_LEN:0]   exp_q[$];
   logic [CHAR_LEN-1:0] msg_buf[0:31];
   int   beats;
   int   fd_cnt;
   int   pad_cnt;
   int   trunc_cnt;
   logic last_trunc;
   logic bp_chk;
   logic bp_on;

   axis_frame_packer #(.CHAR_LEN(CHAR_LEN), .N(N), .PAD_CHAR(PADC)) dut (
      .ACLK          (ACLK),
      .ARESET        (ARESET),
      .S_AXIS_TDATA  (S_AXIS_TDATA),
      .S_AXIS_TVALID (S_AXIS_TVALID),
      .S_AXIS_TLAST  (S_AXIS_TLAST),
      .S_AXIS_TREADY (S_AXIS_TREADY),
      .M_AXIS_TDATA  (M_AXIS_TDATA),
      .M_AXIS_TVALID (M_AXIS_TVALID),
      .M_AXIS_TLAST  (M_AXIS_TLAST),
      .M_AXIS_TREADY (M_AXIS_TREADY),
      .frame_done    (frame_done),
      .truncated     (truncated),
      .padded        (padded)
   );

   initial ACLK = 1'b0;
   always #5 ACLK = ~ACLK;

   // Output monitor: pops the scoreboard on every downstream handshake,
   // checks stall stability and counts the status pulses.
   task automatic monitor();
      logic [CHAR_LEN:0]   e;
      logic                p_stall;
      logic [CHAR_LEN-1:0] p_data;
      logic                p_last;
      p_stall = 1'b0;
      p_data  = '0;
      p_last  = 1'b0;
      forever begin
         @(negedge ACLK);
         if (ARESET) begin
            p_stall = 1'b0;
         end else begin
            if (p_stall) begin
               checks++;
               if ({M_AXIS_TVALID, M_AXIS_TDATA, M_AXIS_TLAST} !== {1'b1, p_data, p_last}) begin
                  failures++;
                  $display("FAIL stall_hold got=%b_%h_%b exp=1_%h_%b", M_AXIS_TVALID,
                           M_AXIS_TDATA, M_AXIS_TLAST, p_data, p_last);
               end
            end
            if (bp_chk && M_AXIS_TVALID && !M_AXIS_TREADY) begin
               checks++;
               if (S_AXIS_TREADY !== 1'b0) begin
                  failures++;
                  $display("FAIL tready_stall got=%b exp=0", S_AXIS_TREADY);
               end
            end
            if (M_AXIS_TVALID && M_AXIS_TREADY) begin
               beats++;
               checks++;
               if (exp_q.size() == 0) begin
                  failures++;
                  $display("FAIL unexpected_beat got=%h_%b exp=none", M_AXIS_TDATA, M_AXIS_TLAST);
               end else begin
                  e = exp_q.pop_front();
                  if ({M_AXIS_TDATA, M_AXIS_TLAST} !== e) begin
                     failures++;
                     $display("FAIL beat_data got=%h_%b exp=%h_%b", M_AXIS_TDATA,
                              M_AXIS_TLAST, e[CHAR_LEN:1], e[0]);
                  end
               end
            end
            if (frame_done === 1'b1) fd_cnt++;
            if (padded === 1'b1)     pad_cnt++;
            if (truncated === 1'b1)  trunc_cnt++;
            p_stall = M_AXIS_TVALID && !M_AXIS_TREADY;
            p_data  = M_AXIS_TDATA;
            p_last  = M_AXIS_TLAST;
         end
      end
   endtask

   task automatic clr_stats();
      beats      = 0;
      fd_cnt     = 0;
      pad_cnt    = 0;
      trunc_cnt  = 0;
      last_trunc = 1'b0;
   endtask

   // Drive msg_buf[0:len-1]; term selects TLAST on the final beat.
   // Expected frame beats (including pads) are queued here.
   task automatic drive_msg(input int len, input bit term);
      bit got;
      int budget;
      for (int i = 0; i < len; i++) begin
         S_AXIS_TDATA  = msg_buf[i];
         S_AXIS_TLAST  = term && (i == len - 1);
         S_AXIS_TVALID = 1'b1;
         if (i < N) exp_q.push_back({msg_buf[i], (i == N - 1)});
         got    = 1'b0;
         budget = 0;
         while (!got && budget < 200) begin
            @(negedge ACLK);
            got = S_AXIS_TREADY;
            if (got && i == len - 1) last_trunc = truncated;
            @(posedge ACLK);
            #1;
            budget++;
         end
         checks++;
         if (!got) begin
            failures++;
            $display("FAIL input_accept_timeout got=0 exp=1 beat=%0d", i);
         end
      end
      if (term && len < N) begin
         for (int k = len; k < N; k++) exp_q.push_back({PADC, (k == N - 1)});
      end
      S_AXIS_TVALID = 1'b0;
      S_AXIS_TLAST  = 1'b0;
   endtask

   task automatic wait_drain();
      int budget;
      budget = 0;
      while (exp_q.size() != 0 && budget < 400) begin
         @(negedge ACLK);
         budget++;
      end
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL drain_timeout got=%0d exp=0 beats_left", exp_q.size());
      end
      @(posedge ACLK);
      #1;
   endtask

   task automatic test_reset();
      ARESET = 1'b1;
      repeat (2) @(posedge ACLK);
      @(negedge ACLK);
      checks++;
      if ({M_AXIS_TVALID, M_AXIS_TDATA, M_AXIS_TLAST} !== {1'b0, 8'h00, 1'b0}) begin
         failures++;
         $display("FAIL reset_out got=%b_%h_%b exp=0_00_0", M_AXIS_TVALID, M_AXIS_TDATA, M_AXIS_TLAST);
      end
      checks++;
      if ({frame_done, truncated, padded} !== 3'b000) begin
         failures++;
         $display("FAIL reset_pulses got=%b exp=000", {frame_done, truncated, padded});
      end
      checks++;
      if (S_AXIS_TREADY !== 1'b0) begin
         failures++;
         $display("FAIL reset_tready got=%b exp=0", S_AXIS_TREADY);
      end
      @(posedge ACLK);
      #1;
      ARESET = 1'b0;
      @(negedge ACLK);
      checks++;
      if (S_AXIS_TREADY !== 1'b1) begin
         failures++;
         $display("FAIL idle_tready got=%b exp=1", S_AXIS_TREADY);
      end
      @(posedge ACLK);
      #1;
   endtask

   task automatic test_exact();
      clr_stats();
      for (int i = 0; i < N - 1; i++) msg_buf[i] = 8'h01;
      msg_buf[N-1] = 8'hff;
      drive_msg(N, 1'b1);
      wait_drain();
      checks++;
      if ({beats, fd_cnt, pad_cnt, trunc_cnt} !== {32'd16, 32'd1, 32'd0, 32'd0}) begin
         failures++;
         $display("FAIL exact_stats got=b%0d_f%0d_p%0d_t%0d exp=b16_f1_p0_t0",
                  beats, fd_cnt, pad_cnt, trunc_cnt);
      end
   endtask

   task automatic test_short();
      clr_stats();
      msg_buf[0] = 8'h41;
      msg_buf[1] = 8'h42;
      msg_buf[2] = 8'h43;
      drive_msg(3, 1'b1);
      wait_drain();
      checks++;
      if ({beats, fd_cnt, pad_cnt, trunc_cnt} !== {32'd16, 32'd1, 32'd1, 32'd0}) begin
         failures++;
         $display("FAIL short_stats got=b%0d_f%0d_p%0d_t%0d exp=b16_f1_p1_t0",
                  beats, fd_cnt, pad_cnt, trunc_cnt);
      end
   endtask

   task automatic test_long();
      clr_stats();
      for (int i = 0; i < 20; i++) msg_buf[i] = 8'(i);
      drive_msg(20, 1'b1);
      wait_drain();
      checks++;
      if ({beats, fd_cnt, pad_cnt, trunc_cnt} !== {32'd16, 32'd1, 32'd0, 32'd1}) begin
         failures++;
         $display("FAIL long_stats got=b%0d_f%0d_p%0d_t%0d exp=b16_f1_p0_t1",
                  beats, fd_cnt, pad_cnt, trunc_cnt);
      end
      checks++;
      if (last_trunc !== 1'b1) begin
         failures++;
         $display("FAIL long_trunc_timing got=%b exp=1", last_trunc);
      end
      clr_stats();
      for (int i = 0; i < N; i++) msg_buf[i] = 8'(8'h80 + i);
      drive_msg(N, 1'b1);
      wait_drain();
      checks++;
      if ({beats, fd_cnt, pad_cnt, trunc_cnt} !== {32'd16, 32'd1, 32'd0, 32'd0}) begin
         failures++;
         $display("FAIL after_long_stats got=b%0d_f%0d_p%0d_t%0d exp=b16_f1_p0_t0",
                  beats, fd_cnt, pad_cnt, trunc_cnt);
      end
   endtask

   task automatic test_backpressure();
      for (int pass = 0; pass < 2; pass++) begin
         clr_stats();
         for (int i = 0; i < N; i++) msg_buf[i] = 8'(8'h20 + 3 * i);
         bp_chk = 1'b1;
         bp_on  = 1'b1;
         fork
            begin
               drive_msg((pass == 0) ? N : 5, 1'b1);
               wait_drain();
               bp_on = 1'b0;
            end
            begin
               for (int k = 0; bp_on && k < 2000; k++) begin
                  @(posedge ACLK);
                  #1;
                  if (bp_on) M_AXIS_TREADY = (k % 3 == 0);
               end
            end
         join
         M_AXIS_TREADY = 1'b1;
         bp_chk        = 1'b0;
         @(posedge ACLK);
         #1;
         checks++;
         if ({beats, fd_cnt, pad_cnt} !== {32'd16, 32'd1, (pass == 0) ? 32'd0 : 32'd1}) begin
            failures++;
            $display("FAIL bp_stats pass=%0d got=b%0d_f%0d_p%0d exp=b16_f1_p%0d",
                     pass, beats, fd_cnt, pad_cnt, pass);
         end
      end
   endtask

   task automatic test_single();
      clr_stats();
      msg_buf[0] = 8'h7a;
      drive_msg(1, 1'b1);
      wait_drain();
      checks++;
      if ({beats, fd_cnt, pad_cnt, trunc_cnt} !== {32'd16, 32'd1, 32'd1, 32'd0}) begin
         failures++;
         $display("FAIL single_stats got=b%0d_f%0d_p%0d_t%0d exp=b16_f1_p1_t0",
                  beats, fd_cnt, pad_cnt, trunc_cnt);
      end
   endtask

   task automatic test_mid_reset();
      clr_stats();
      for (int i = 0; i < 5; i++) msg_buf[i] = 8'(8'h50 + i);
      drive_msg(5, 1'b0);
      ARESET = 1'b1;
      @(negedge ACLK);
      checks++;
      if (S_AXIS_TREADY !== 1'b0) begin
         failures++;
         $display("FAIL midreset_tready got=%b exp=0", S_AXIS_TREADY);
      end
      @(posedge ACLK);
      #1;
      ARESET = 1'b0;
      checks++;
      if ({M_AXIS_TVALID, M_AXIS_TDATA, M_AXIS_TLAST, frame_done, truncated, padded}
          !== {1'b0, 8'h00, 1'b0, 3'b000}) begin
         failures++;
         $display("FAIL midreset_out got=%b_%h_%b_%b exp=0_00_0_000", M_AXIS_TVALID,
                  M_AXIS_TDATA, M_AXIS_TLAST, {frame_done, truncated, padded});
      end
      exp_q.delete();
      clr_stats();
      for (int i = 0; i < N; i++) msg_buf[i] = 8'(8'hc0 + i);
      drive_msg(N, 1'b1);
      wait_drain();
      checks++;
      if ({beats, fd_cnt, pad_cnt, trunc_cnt} !== {32'd16, 32'd1, 32'd0, 32'd0}) begin
         failures++;
         $display("FAIL midreset_frame got=b%0d_f%0d_p%0d_t%0d exp=b16_f1_p0_t0",
                  beats, fd_cnt, pad_cnt, trunc_cnt);
      end
   endtask

   initial begin
      ARESET        = 1'b1;
      S_AXIS_TDATA  = '0;
      S_AXIS_TVALID = 1'b0;
      S_AXIS_TLAST  = 1'b0;
      M_AXIS_TREADY = 1'b1;
      bp_chk        = 1'b0;
      bp_on         = 1'b0;
      clr_stats();
      fork
         monitor();
      join_none
      test_reset();
      test_exact();
      test_short();
      test_long();
      test_backpressure();
      test_single();
      test_mid_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
